// File: rtl/cache_fsm_pkg.sv
// Shared types for the multi-line cache controller.
//   state_e : controller FSM states.
//   IDX_W / OFF_W : index and offset widths for the default geometry
//                   (8 lines x 16 words); parametrised modules derive
//                   their own widths from NUM_LINES / BLOCK_WORDS.
package cache_fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_HIT   = 3'd2,
    S_WB    = 3'd3,
    S_FILL  = 3'd4
  } state_e;

  localparam int DEF_NUM_LINES   = 8;
  localparam int DEF_BLOCK_WORDS = 16;
  localparam int IDX_W = $clog2(DEF_NUM_LINES);
  localparam int OFF_W = $clog2(DEF_BLOCK_WORDS);

endpackage

// File: rtl/cache_fsm_multi_sdram_beat_timer.sv
// SDRAM beat timer: while en is high, counts 0..SDRAM_LAT and wraps, so
// each beat lasts SDRAM_LAT+1 cycles. Dropping en returns it to 0.
//   clk, rst (sync, active-low)
//   en         : count while high
//   beat_start : first cycle of a beat (drives memstrb)
//   beat_last  : final cycle of a beat
module sdram_beat_timer
  import cache_fsm_pkg::*;
#(
  parameter int SDRAM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic beat_start,
  output logic beat_last
);

  localparam int CNT_W = $clog2(SDRAM_LAT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign beat_start = en && (cnt_q == '0);
  assign beat_last  = en && (cnt_q == CNT_W'(SDRAM_LAT));

  always_comb begin
    cnt_d = '0;
    if (en && !beat_last) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cache_fsm_multi.sv
// Controller for a direct-mapped write-back cache of NUM_LINES lines x
// BLOCK_WORDS words. Holds per-line valid/dirty bits and sequences the
// CPU hit path, dirty-line write-back and line fill over SDRAM.
//   Inputs : clk, rst (sync, active-low), cs_sampled_dly (request strobe,
//            seen in IDLE only), wr_rd_cpu_q, hit, index.
//   Outputs: dirty/valid of the latched line, mux_sel/demux_sel (SRAM data
//            routing), rdy, wen_sram, wr_rd_sdram, addr_offset_counter,
//            memstrb, tag_wen, hit_cnt/miss_cnt/wb_cnt.
// Optional: define CACHE_STATS_EN to build saturating statistics counters;
// otherwise the three counter ports are tied to zero.
module cache_fsm_multi
  import cache_fsm_pkg::*;
#(
  parameter int NUM_LINES   = 8,
  parameter int BLOCK_WORDS = 16,
  parameter int SDRAM_LAT   = 2,
  parameter int STAT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cs_sampled_dly,
  input  logic                           wr_rd_cpu_q,
  input  logic                           hit,
  input  logic [$clog2(NUM_LINES)-1:0]   index,
  output logic                           dirty,
  output logic                           valid,
  output logic                           mux_sel,
  output logic                           demux_sel,
  output logic                           rdy,
  output logic                           wen_sram,
  output logic                           wr_rd_sdram,
  output logic [$clog2(BLOCK_WORDS)-1:0] addr_offset_counter,
  output logic                           memstrb,
  output logic                           tag_wen,
  output logic [STAT_W-1:0]              hit_cnt,
  output logic [STAT_W-1:0]              miss_cnt,
  output logic [STAT_W-1:0]              wb_cnt
);

  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int OFF_BITS = $clog2(BLOCK_WORDS);

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [NUM_LINES-1:0]  dirty_q, dirty_d;
  logic [OFF_BITS-1:0]   off_q, off_d;
  logic                  beat_start, beat_last, timer_en;

  assign timer_en = (state_q == S_WB) || (state_q == S_FILL);

  sdram_beat_timer #(.SDRAM_LAT(SDRAM_LAT)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .en         (timer_en),
    .beat_start (beat_start),
    .beat_last  (beat_last)
  );

  assign memstrb             = beat_start;
  assign addr_offset_counter = off_q;
  assign valid               = valid_q[idx_q];
  assign dirty               = dirty_q[idx_q];

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    off_d       = off_q;
    rdy         = 1'b0;
    wen_sram    = 1'b0;
    mux_sel     = 1'b0;
    demux_sel   = 1'b0;
    wr_rd_sdram = 1'b0;
    tag_wen     = 1'b0;
    case (state_q)
      S_IDLE: begin
        rdy = 1'b1;
        if (cs_sampled_dly) begin
          wr_d    = wr_rd_cpu_q;
          idx_d   = index;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // A tag match on an invalid line is still a miss.
        if (hit && valid_q[idx_q])                  state_d = S_HIT;
        else if (valid_q[idx_q] && dirty_q[idx_q])  state_d = S_WB;
        else                                        state_d = S_FILL;
      end
      S_HIT: begin
        wen_sram = wr_q;
        if (wr_q) dirty_d[idx_q] = 1'b1;
        state_d = S_IDLE;
      end
      S_WB: begin
        wr_rd_sdram = 1'b1;
        demux_sel   = 1'b1;
        if (beat_last) begin
          if (off_q == '1) begin
            off_d   = '0;
            state_d = S_FILL;
          end else begin
            off_d = off_q + OFF_BITS'(1);
          end
        end
      end
      S_FILL: begin
        mux_sel  = 1'b1;
        // SDRAM read data is valid at the end of the beat.
        wen_sram = beat_last;
        if (beat_last) begin
          if (off_q == '1) begin
            tag_wen        = 1'b1;
            valid_d[idx_q] = 1'b1;
            dirty_d[idx_q] = 1'b0;
            off_d          = '0;
            state_d        = S_HIT;
          end else begin
            off_d = off_q + OFF_BITS'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      off_q   <= off_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [STAT_W-1:0] wb_cnt_q, wb_cnt_d;

  // Classification happens on the CHECK exit; counters stick at all-ones.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (state_q == S_CHECK) begin
      if (state_d == S_HIT) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + STAT_W'(1);
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + STAT_W'(1);
        if (state_d == S_WB && wb_cnt_q != '1) wb_cnt_d = wb_cnt_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
  assign wb_cnt   = '0;
`endif

endmodule

// File: tb/tb_cache_fsm_multi.sv
// Bench for cache_fsm_multi (4 lines x 16 words, SDRAM_LAT=2).
// The driver issues directed requests and queues the expected outcome of
// each; the monitor measures every transaction from the outputs and
// compares against the queue head when rdy returns.
module tb_cache_fsm_multi;

  localparam int NL  = 4;
  localparam int BW  = 16;
  localparam int LAT = 2;
  localparam int SW  = 16;

  localparam int K_TXN = 0;
  localparam int K_RST = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          cs_sampled_dly = 1'b0;
  logic          wr_rd_cpu_q = 1'b0;
  logic          hit = 1'b0;
  logic [1:0]    index = '0;
  logic          dirty, valid, mux_sel, demux_sel, rdy, wen_sram, wr_rd_sdram;
  logic [3:0]    addr_offset_counter;
  logic          memstrb, tag_wen;
  logic [SW-1:0] hit_cnt, miss_cnt, wb_cnt;

  cache_fsm_multi #(.NUM_LINES(NL), .BLOCK_WORDS(BW), .SDRAM_LAT(LAT), .STAT_W(SW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cs_sampled_dly      (cs_sampled_dly),
    .wr_rd_cpu_q         (wr_rd_cpu_q),
    .hit                 (hit),
    .index               (index),
    .dirty               (dirty),
    .valid               (valid),
    .mux_sel             (mux_sel),
    .demux_sel           (demux_sel),
    .rdy                 (rdy),
    .wen_sram            (wen_sram),
    .wr_rd_sdram         (wr_rd_sdram),
    .addr_offset_counter (addr_offset_counter),
    .memstrb             (memstrb),
    .tag_wen             (tag_wen),
    .hit_cnt             (hit_cnt),
    .miss_cnt            (miss_cnt),
    .wb_cnt              (wb_cnt)
  );

  typedef struct {
    int kind;
    string name;
    int lat;
    int n_strb;
    int n_strb_wb;
    int n_wen;
    int n_wen_mux;
    int n_tag;
    int v;
    int d;
    int hc;
    int mc;
    int wc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int eh = 0, em = 0, ew = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(int kind, string name, int lat, int ns, int nwb, int nw,
                              int nwm, int nt, int v, int d);
    exp_t e;
    e.kind = kind; e.name = name; e.lat = lat; e.n_strb = ns; e.n_strb_wb = nwb;
    e.n_wen = nw; e.n_wen_mux = nwm; e.n_tag = nt; e.v = v; e.d = d;
`ifdef CACHE_STATS_EN
    e.hc = eh; e.mc = em; e.wc = ew;
`else
    e.hc = 0; e.mc = 0; e.wc = 0;
`endif
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit in_txn = 0;
  bit rst_pend = 0;
  int c, n_strb, n_wb, n_wen, n_wenm, n_tag, off_err, gap_err, wpos_err, last_c;

  always @(negedge clk) begin
    exp_t e;
    if (rst_pend) begin
      in_txn = 0;
      if (exp_q.size() > 0 && exp_q[0].kind == K_RST) begin
        e = exp_q.pop_front();
        chk({e.name, ".rdy"}, 64'(rdy), 64'd1);
        chk({e.name, ".memstrb"}, 64'(memstrb), 64'd0);
        chk({e.name, ".wen_sram"}, 64'(wen_sram), 64'd0);
        chk({e.name, ".tag_wen"}, 64'(tag_wen), 64'd0);
        chk({e.name, ".offset"}, 64'(addr_offset_counter), 64'd0);
        chk({e.name, ".sdram_mux"}, 64'({mux_sel, demux_sel, wr_rd_sdram}), 64'd0);
        chk({e.name, ".valid_dirty"}, 64'({valid, dirty}), 64'd0);
        chk({e.name, ".all_valid"}, 64'(dut.valid_q), 64'd0);
        chk({e.name, ".stats"}, 64'(hit_cnt) + 64'(miss_cnt) + 64'(wb_cnt), 64'd0);
        $display("reset %s: rdy=%0b memstrb=%0b offset=%0d", e.name, rdy, memstrb,
                 addr_offset_counter);
      end
    end else if (in_txn) begin
      c++;
      if (memstrb) begin
        n_strb++;
        if (wr_rd_sdram && demux_sel) n_wb++;
        if (int'(addr_offset_counter) != (n_strb - 1) % BW) off_err++;
        if (n_strb > 1 && c - last_c != LAT + 1) gap_err++;
        last_c = c;
      end
      if (wen_sram) begin
        n_wen++;
        if (mux_sel) begin
          n_wenm++;
          if (c - last_c != LAT) wpos_err++;
        end
      end
      if (tag_wen) n_tag++;
      if (rdy || c > 300) begin
        in_txn = 0;
        if (exp_q.size() == 0 || exp_q[0].kind != K_TXN) begin
          chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, ".latency"}, 64'(c), 64'(e.lat));
          chk({e.name, ".memstrb"}, 64'(n_strb), 64'(e.n_strb));
          chk({e.name, ".wb_beats"}, 64'(n_wb), 64'(e.n_strb_wb));
          chk({e.name, ".wen"}, 64'(n_wen), 64'(e.n_wen));
          chk({e.name, ".wen_fill"}, 64'(n_wenm), 64'(e.n_wen_mux));
          chk({e.name, ".tag_wen"}, 64'(n_tag), 64'(e.n_tag));
          chk({e.name, ".offset_seq_err"}, 64'(off_err), 64'd0);
          chk({e.name, ".beat_gap_err"}, 64'(gap_err), 64'd0);
          chk({e.name, ".fill_wen_pos_err"}, 64'(wpos_err), 64'd0);
          chk({e.name, ".valid"}, 64'(valid), 64'(e.v));
          chk({e.name, ".dirty"}, 64'(dirty), 64'(e.d));
          chk({e.name, ".hit_cnt"}, 64'(hit_cnt), 64'(e.hc));
          chk({e.name, ".miss_cnt"}, 64'(miss_cnt), 64'(e.mc));
          chk({e.name, ".wb_cnt"}, 64'(wb_cnt), 64'(e.wc));
          $display("txn %s: lat=%0d strb=%0d wb=%0d wen=%0d tag=%0d v=%0b d=%0b",
                   e.name, c, n_strb, n_wb, n_wen, n_tag, valid, dirty);
        end
      end
    end else if (rst) begin
      chk("idle_quiet", 64'({memstrb, wen_sram, tag_wen}), 64'd0);
    end
    if (rst && !rst_pend && !in_txn && rdy && cs_sampled_dly) begin
      in_txn = 1;
      c = 0; n_strb = 0; n_wb = 0; n_wen = 0; n_wenm = 0; n_tag = 0;
      off_err = 0; gap_err = 0; wpos_err = 0; last_c = 0;
    end
    rst_pend = (rst == 1'b0);
  end

  // ---------------- driver ----------------
  // Entered and left at posedge+1. Index and hit are disturbed after
  // acceptance to show the operation uses the latched/checked values.
  task automatic issue(input bit wr, input int idx, input bit h, input int new_idx,
                       input bit pulse);
    int n;
    cs_sampled_dly = 1'b1; wr_rd_cpu_q = wr; index = 2'(idx); hit = h;
    @(posedge clk); #1;
    cs_sampled_dly = 1'b0; index = 2'(new_idx);
    @(posedge clk); #1;
    hit = ~h;
    if (pulse) begin
      repeat (10) @(posedge clk);
      #1 cs_sampled_dly = 1'b1; index = 2'd2;
      @(posedge clk); #1 cs_sampled_dly = 1'b0;
    end
    n = 0;
    while (!rdy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy) chk("driver_rdy_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    exp_q.push_back(mk(K_RST, "por", 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    em++;
    exp_q.push_back(mk(K_TXN, "rd_miss_i1", 51, 16, 0, 16, 16, 1, 1, 0));
    issue(1'b0, 1, 1'b0, 3, 1'b0);

    eh++;
    exp_q.push_back(mk(K_TXN, "wr_hit_i1", 3, 0, 0, 1, 0, 0, 1, 1));
    issue(1'b1, 1, 1'b1, 1, 1'b0);

    em++; ew++;
    exp_q.push_back(mk(K_TXN, "wr_miss_dirty_i1", 99, 32, 16, 17, 16, 1, 1, 1));
    issue(1'b1, 1, 1'b0, 0, 1'b1);

    em++;
    exp_q.push_back(mk(K_TXN, "hit_invalid_i2", 51, 16, 0, 16, 16, 1, 1, 0));
    issue(1'b0, 2, 1'b1, 2, 1'b0);

    // Abort a fill partway through; no record for the aborted access.
    cs_sampled_dly = 1'b1; wr_rd_cpu_q = 1'b0; index = 2'd0; hit = 1'b0;
    @(posedge clk); #1 cs_sampled_dly = 1'b0;
    n = 0;
    while (!(mux_sel && addr_offset_counter == 4'd5) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_fill_off5", 64'(mux_sel && addr_offset_counter == 4'd5), 64'd1);
    eh = 0; em = 0; ew = 0;
    exp_q.push_back(mk(K_RST, "mid_fill", 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    em++;
    exp_q.push_back(mk(K_TXN, "rd_miss_i0_after_rst", 51, 16, 0, 16, 16, 1, 1, 0));
    issue(1'b0, 0, 1'b0, 0, 1'b0);

    eh++;
    exp_q.push_back(mk(K_TXN, "rd_hit_i0", 3, 0, 0, 0, 0, 0, 1, 0));
    issue(1'b0, 0, 1'b1, 3, 1'b0);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_fsm_multi.md
Name: cache_fsm_multi

Overview:
- Parametrised successor to the single-line cache controller FSM.
- Controls one direct-mapped, write-back cache with NUM_LINES lines of BLOCK_WORDS words each, and keeps per-line valid/dirty bits internally.
- Sequences the CPU hit path, dirty-line write-back to SDRAM and line fill from SDRAM, with a configurable SDRAM beat latency.
- Sits between the CPU request sampler / tag compare and the SRAM data path / SDRAM interface.

Parameters:
- NUM_LINES, 8, number of cache lines; power of 2, ≥2.
- BLOCK_WORDS, 16, words per line; power of 2, ≥2.
- SDRAM_LAT, 2, wait cycles after each memstrb pulse; ≥1.
- STAT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- cs_sampled_dly  in  1  CPU request strobe; sampled only in IDLE.
- wr_rd_cpu_q  in  1  1=write, 0=read; latched with the request.
- hit  in  1  tag-compare match for the current request.
- index  in  $clog2(NUM_LINES)  line index of the request; latched with the request.
- dirty  out  1  dirty bit of the latched line.
- valid  out  1  valid bit of the latched line.
- mux_sel  out  1  SRAM write-data source: 0=CPU, 1=SDRAM.
- demux_sel  out  1  SRAM read-data destination: 0=CPU, 1=SDRAM.
- rdy  out  1  controller idle and able to accept a request.
- wen_sram  out  1  SRAM word write enable.
- wr_rd_sdram  out  1  1=SDRAM write, 0=SDRAM read.
- addr_offset_counter  out  $clog2(BLOCK_WORDS)  word offset within the line.
- memstrb  out  1  SDRAM beat strobe.
- tag_wen  out  1  one-cycle pulse that loads the new tag.
- hit_cnt, miss_cnt, wb_cnt  out  STAT_W each  statistics counters (see Optional Feature).

Behaviour:
- All outputs are decoded from registered state.
- Reset (rst=0 at an edge):
  - state=IDLE, all valid/dirty bits=0, offset counter=0, beat timer=0, stats=0.
  - After reset: rdy=1, every other output 0.
  - Reset mid-operation aborts immediately; no further memstrb or wen_sram pulses.
- States: IDLE, CHECK, HIT, WB, FILL.
- IDLE:
  - rdy=1.
  - cs_sampled_dly=1 latches wr_rd_cpu_q and index, then goes to CHECK.
  - cs_sampled_dly is ignored in every other state.
- CHECK (1 cycle):
  - hit && valid[idx] → HIT.
  - Miss && valid && dirty → WB.
  - Otherwise → FILL.
  - hit=1 with valid=0 is a miss.
- HIT (1 cycle):
  - wen_sram=wr, mux_sel=0, demux_sel=0.
  - On a write, dirty[idx] is set.
  - → IDLE.
- Beat timing: each beat lasts SDRAM_LAT+1 cycles.
  - memstrb=1 in cycle 0 only.
  - addr_offset_counter stays constant through the beat and increments after its last cycle.
- WB:
  - wr_rd_sdram=1 and demux_sel=1 throughout.
  - BLOCK_WORDS beats, offsets 0..BLOCK_WORDS-1.
  - After the last beat, the counter wraps to 0 and the FSM goes to FILL.
- FILL:
  - wr_rd_sdram=0 and mux_sel=1 throughout.
  - wen_sram=1 in the last cycle of each beat.
  - On the last beat's final cycle: tag_wen=1, valid[idx]←1, dirty[idx]←0, counter←0, → HIT.
  - HIT then completes the CPU access, so a write miss ends with dirty=1.
- Latency from the accepting edge back to rdy=1:
  - Hit: 3 cycles.
  - Clean miss: 3+BLOCK_WORDS·(SDRAM_LAT+1).
  - Dirty miss: 3+2·BLOCK_WORDS·(SDRAM_LAT+1).
- Input stability: index and hit changes after acceptance do not affect the current operation. hit is used only in CHECK.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined:
  - hit_cnt increments on CHECK→HIT.
  - miss_cnt increments on CHECK→WB or CHECK→FILL.
  - wb_cnt increments on entry to WB.
  - All three saturate at 2^STAT_W-1 and are cleared by reset.
- When undefined: the three ports are tied to 0 and no counter logic is built.

Decomposition:
- Package cache_fsm_pkg:
  - state enum typedef.
  - Width helper localparams (IDX_W, OFF_W).
- One sub-module, sdram_beat_timer:
  - Counts 0..SDRAM_LAT while enabled.
  - Outputs beat_start (drives memstrb) and beat_last.

Test Plan (NUM_LINES=4, BLOCK_WORDS=16, SDRAM_LAT=2):
- Read miss, idx=1, hit=0 → 16 memstrb pulses 3 cycles apart; 16 wen_sram with mux_sel=1; offsets 0..15; tag_wen once; valid=1, dirty=0; rdy=1 again 51 cycles after acceptance.
- Write hit, idx=1, hit=1 → single wen_sram with mux_sel=0; dirty=1; rdy back after 3 cycles; no memstrb.
- Write miss, idx=1, hit=0, dirty line → 16 WB beats with wr_rd_sdram=1 and demux_sel=1, then 16 FILL beats; dirty=1 at end; rdy back after 99 cycles.
- hit=1 on invalid idx=2 → treated as miss: FILL, no WB; rdy after 51 cycles.
- rst=0 during FILL at offset 5 → next edge: state IDLE, rdy=1, memstrb=0, counter=0; valid reads 0 for all lines.
- cs_sampled_dly pulsed during WB → ignored. With CACHE_STATS_EN and the sequence above: hit_cnt=1, miss_cnt=3, wb_cnt=1.
